t48_stack_ctrl: RTL
===================

T48_STACK_CTRL -- requirements
Module: t48_stack_ctrl

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk_i  in  1  system clock
- res_i  in  1  asynchronous active-low reset
- en_clk_i  in  1  clock enable; state advances only when high
- push_req_i  in  1  CALL/interrupt: push PC and PSW
- pop_req_i  in  1  RET/RETR: pop PC
- restore_psw_i  in  1  sampled with pop_req_i; high means RETR (also restore PSW)
- pc_i  in  12  current PC
- psw_i  in  4  PSW upper nibble {CY,AC,F0,BS}
- sp_i  in  3  current stack pointer
- ram_data_i  in  8  internal RAM read data; valid one enabled cycle after address
- ram_addr_o  out  8  internal RAM address
- ram_we_o  out  1  RAM write strobe
- ram_data_o  out  8  RAM write data
- inc_stackp_o  out  1  stack pointer increment strobe
- dec_stackp_o  out  1  stack pointer decrement strobe
- pc_o  out  12  restored PC
- pc_load_o  out  1  pc_o valid strobe
- psw_o  out  4  restored PSW nibble
- write_psw_o  out  1  psw_o valid strobe (RETR only)
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle completion pulse
REQ-002 SHALL use one clock (clk_i) and an asynchronous, active-low reset (res_i).

Function
REQ-003 SHALL implement FSM states IDLE, PUSH_LO, PUSH_HI, POP_LO, POP_HI, POP_CAP; transitions occur only on enabled cycles.
REQ-004 SHALL, in IDLE with push_req_i=1, capture pc_i, psw_i, sp_i and go to PUSH_LO; push_req_i SHALL win over a simultaneous pop_req_i.
REQ-005 SHALL, in IDLE with pop_req_i=1 (no push), capture sp_i and restore_psw_i and go to POP_LO.
REQ-006 SHALL compute the stack slot address as 8 + 2*slot, 8-bit result: lo byte at 8+2*slot, hi byte at 9+2*slot.
REQ-007 PUSH_LO: slot = captured SP; ram_addr_o = lo address; ram_data_o = PC[7:0]; ram_we_o=1; next PUSH_HI.
REQ-008 PUSH_HI: ram_addr_o = hi address; ram_data_o = {PSW[3:0], PC[11:8]}; ram_we_o=1; inc_stackp_o=1; next IDLE with done_o=1 in the following cycle.
REQ-009 POP_LO: slot = (captured SP - 1) mod 8; ram_addr_o = lo address; dec_stackp_o=1; next POP_HI.
REQ-010 POP_HI: ram_addr_o = hi address; ram_data_i (lo byte) captured; next POP_CAP.
REQ-011 POP_CAP: ram_data_i (hi byte) captured; pc_o = {hi[3:0], lo}; pc_load_o=1; if RETR, psw_o = hi[7:4] and write_psw_o=1; done_o=1; next IDLE.
REQ-012 SHALL wrap the slot modulo 8: push at SP=7 uses addresses 22/23; pop at SP=0 uses addresses 22/23.
REQ-013 SHALL ignore push_req_i/pop_req_i while busy_o=1; busy_o SHALL be high in every state except IDLE.
REQ-014 SHALL force ram_we_o, inc_stackp_o, dec_stackp_o, pc_load_o, write_psw_o and done_o low on any cycle with en_clk_i=0, holding state and captured registers.
REQ-015 SHALL hold ram_addr_o, ram_data_o, pc_o and psw_o stable outside their active states (last value).

Reset
REQ-016 SHALL, when res_i=0, immediately set state IDLE, all outputs 0, and all captured registers 0, aborting any sequence without further RAM writes or SP strobes.
REQ-017 SHALL accept a request on the first enabled cycle after res_i rises.

Structure
REQ-018 SHALL place the state enumeration and constants STACK_BASE=8 and SLOT_BYTES=2 in the shared t48 package.
REQ-019 SHALL be a single module with no sub-modules; address generation is a local function.

Verification
REQ-020 Push: SP=3, PC=0x5A7, PSW=0xA, en=1 -> writes 0xA7@14, 0xA5@15 on consecutive cycles, inc_stackp_o one cycle with the second write, done_o next cycle.
REQ-021 RETR: SP=4, RAM[14]=0xA7, RAM[15]=0xA5 -> dec_stackp_o in POP_LO, pc_o=0x5A7 with pc_load_o, psw_o=0xA with write_psw_o, 3 enabled cycles after acceptance.
REQ-022 RET (restore_psw_i=0) at SP=0 -> reads addresses 22/23, pc_load_o=1, write_psw_o stays 0.
REQ-023 Simultaneous push_req_i=pop_req_i=1 in IDLE -> push sequence; second request during busy ignored.
REQ-024 en_clk_i low for 2 cycles mid-push -> no strobes during stall, sequence resumes unchanged.
REQ-025 res_i low during PUSH_HI -> outputs 0 at once, no inc_stackp_o, IDLE after release.

Source files
------------

// File: rtl/t48_stack_ctrl_pkg.sv
// Shared T48 stack-controller types and constants.
package t48_stack_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_LO = 3'd1,
    S_PUSH_HI = 3'd2,
    S_POP_LO  = 3'd3,
    S_POP_HI  = 3'd4,
    S_POP_CAP = 3'd5
  } stack_state_e;

  localparam logic [7:0] STACK_BASE = 8'd8;
  localparam logic [7:0] SLOT_BYTES = 8'd2;

endpackage

// File: rtl/t48_stack_ctrl.sv
// T48 CALL/RET stack sequencer: pushes PC+PSW into two internal-RAM bytes and pops them back.
// Every state change, capture and strobe is qualified by en_clk_i; outputs hold their last value when idle.
module t48_stack_ctrl
  import t48_stack_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        en_clk_i,
  input  logic        push_req_i,
  input  logic        pop_req_i,
  input  logic        restore_psw_i,
  input  logic [11:0] pc_i,
  input  logic [3:0]  psw_i,
  input  logic [2:0]  sp_i,
  input  logic [7:0]  ram_data_i,
  output logic [7:0]  ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_data_o,
  output logic        inc_stackp_o,
  output logic        dec_stackp_o,
  output logic [11:0] pc_o,
  output logic        pc_load_o,
  output logic [3:0]  psw_o,
  output logic        write_psw_o,
  output logic        busy_o,
  output logic        done_o
);

  stack_state_e state_q, state_d;
  logic [11:0]  pc_cap_q, pc_cap_d;
  logic [3:0]   psw_cap_q, psw_cap_d;
  logic [2:0]   sp_cap_q, sp_cap_d;
  logic         retr_q, retr_d;
  logic [7:0]   lo_q, lo_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   wdat_q, wdat_d;
  logic [11:0]  pc_q, pc_d;
  logic [3:0]   psw_q, psw_d;
  logic         done_push_q, done_push_d;
  logic [2:0]   pop_slot;

  function automatic logic [7:0] slot_addr(input logic [2:0] slot, input logic hi);
    return STACK_BASE + SLOT_BYTES * {5'd0, slot} + {7'd0, hi};
  endfunction

  // A pop reads the slot below the current stack pointer; 3-bit arithmetic gives the mod-8 wrap.
  assign pop_slot = sp_cap_q - 3'd1;

  always_comb begin
    state_d      = state_q;
    pc_cap_d     = pc_cap_q;
    psw_cap_d    = psw_cap_q;
    sp_cap_d     = sp_cap_q;
    retr_d       = retr_q;
    lo_d         = lo_q;
    addr_d       = addr_q;
    wdat_d       = wdat_q;
    pc_d         = pc_q;
    psw_d        = psw_q;
    done_push_d  = done_push_q;
    ram_we_o     = 1'b0;
    inc_stackp_o = 1'b0;
    dec_stackp_o = 1'b0;
    pc_load_o    = 1'b0;
    write_psw_o  = 1'b0;
    done_o       = 1'b0;
    if (en_clk_i) begin
      unique case (state_q)
        S_IDLE: begin
          // Push completion is reported one enabled cycle after the final write.
          if (done_push_q) begin
            done_o      = 1'b1;
            done_push_d = 1'b0;
          end
          if (push_req_i) begin
            pc_cap_d  = pc_i;
            psw_cap_d = psw_i;
            sp_cap_d  = sp_i;
            state_d   = S_PUSH_LO;
          end else if (pop_req_i) begin
            sp_cap_d = sp_i;
            retr_d   = restore_psw_i;
            state_d  = S_POP_LO;
          end
        end
        S_PUSH_LO: begin
          addr_d   = slot_addr(sp_cap_q, 1'b0);
          wdat_d   = pc_cap_q[7:0];
          ram_we_o = 1'b1;
          state_d  = S_PUSH_HI;
        end
        S_PUSH_HI: begin
          addr_d       = slot_addr(sp_cap_q, 1'b1);
          wdat_d       = {psw_cap_q, pc_cap_q[11:8]};
          ram_we_o     = 1'b1;
          inc_stackp_o = 1'b1;
          done_push_d  = 1'b1;
          state_d      = S_IDLE;
        end
        S_POP_LO: begin
          addr_d       = slot_addr(pop_slot, 1'b0);
          dec_stackp_o = 1'b1;
          state_d      = S_POP_HI;
        end
        S_POP_HI: begin
          addr_d  = slot_addr(pop_slot, 1'b1);
          lo_d    = ram_data_i;
          state_d = S_POP_CAP;
        end
        S_POP_CAP: begin
          pc_d      = {ram_data_i[3:0], lo_q};
          pc_load_o = 1'b1;
          if (retr_q) begin
            psw_d       = ram_data_i[7:4];
            write_psw_o = 1'b1;
          end
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ram_addr_o = addr_d;
  assign ram_data_o = wdat_d;
  assign pc_o       = pc_d;
  assign psw_o      = psw_d;
  assign busy_o     = (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      state_q     <= S_IDLE;
      pc_cap_q    <= '0;
      psw_cap_q   <= '0;
      sp_cap_q    <= '0;
      retr_q      <= 1'b0;
      lo_q        <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      pc_q        <= '0;
      psw_q       <= '0;
      done_push_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_cap_q    <= pc_cap_d;
      psw_cap_q   <= psw_cap_d;
      sp_cap_q    <= sp_cap_d;
      retr_q      <= retr_d;
      lo_q        <= lo_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      pc_q        <= pc_d;
      psw_q       <= psw_d;
      done_push_q <= done_push_d;
    end
  end

endmodule
